booth_mult_param: RTL and testbench
===================================

# booth_mult_param

Parametrised sequential Booth multiplier (radix-2) for the datapath's HI/LO multiply unit. It supports both signed and unsigned operands through a per-operation mode bit and uses an explicit start/busy/done handshake. It computes a full 2·WIDTH-bit product over WIDTH+1 iterations and holds the result on hi/lo until the next operation completes. It is the drop-in successor to the fixed 32-bit multiplier: the control FSM stalls on busy and latches on done.

## Interface
- WIDTH, 32, operand width in bits; legal range 4..64.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset; clock clock.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- hi  out  WIDTH  upper half of product.
- lo  out  WIDTH  lower half of product.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo receive a new result.

## Operation
- States: IDLE, RUN.
- IDLE + start=1: latch the operands and go to RUN; busy=1 and step counter=0.
  - Multiplicand M = a extended to WIDTH+2 bits: sign-extended if is_signed, zero-extended otherwise.
  - Register Q = b extended to WIDTH+1 bits the same way.
  - Accumulator A (WIDTH+2 bits) = 0; Booth bit q_-1 = 0.
- IDLE + start=0: hold all registers; done=0.
- RUN, one Booth step per clock:
  - {Q[0], q_-1} = 01: A = A + M.
  - {Q[0], q_-1} = 10: A = A − M.
  - {Q[0], q_-1} = 00 or 11: A unchanged.
  - Then arithmetic right shift of {A, Q, q_-1} by 1; the sign of A is replicated.
  - Counter increments after each step.
- After step WIDTH+1 (counter reaches WIDTH+1):
  - hi = product[2·WIDTH−1:WIDTH] and lo = product[WIDTH−1:0], where product = {A, Q}.
  - done=1 and busy=0 for that cycle; state returns to IDLE.
- Width rules:
  - The WIDTH+1-bit extension makes unsigned operands behave as positive signed values.
  - The WIDTH+2-bit accumulator absorbs M = most-negative without overflow.
  - Bits of {A, Q} above 2·WIDTH are discarded.
- start while busy=1: ignored. It is not queued, and operands and mode are unaffected.
- Operand changes on a/b/is_signed during RUN: no effect.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, A/Q/M/q_-1/counter=0.
- Reset has priority over everything. Reset mid-RUN aborts the operation: no done pulse, hi/lo cleared to 0.
- Start accepted at rising edge N, so busy=1 from edge N.
- Steps execute at edges N+1 … N+WIDTH+1.
- hi/lo update and done rises at edge N+WIDTH+1; busy falls at the same edge.
- Latency: WIDTH+1 cycles from the acceptance edge (33 for WIDTH=32).
- done lasts exactly one cycle.
- start=1 in the done cycle is accepted at the next edge (back-to-back issue). The throughput limit is one operation per WIDTH+2 cycles.
- hi/lo are stable outside the done edge; they change only at a done edge or on reset.

## Test plan
- Signed small values, WIDTH=32, a=7, b=−3 (0xFFFFFFFD), is_signed=1 -> after 33 cycles: done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned extreme: a=b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001. Repeat with is_signed=1 -> hi=0, lo=1.
- Most-negative operands: a=b=0x80000000, is_signed=1 -> hi=0x40000000, lo=0. Repeat with is_signed=0 -> hi=0x40000000, lo=0.
- Handshake:
  - Pulse start while busy, with different operands, 10 cycles after acceptance -> the first result is unaffected, exactly one done pulse occurs, and busy is high for exactly 33 cycles.
  - Then issue back-to-back starts in the done cycle -> the second done pulse arrives 34 cycles after the first.
- Reset mid-operation:
  - Assert reset at cycle 15 of RUN -> busy=0, hi=lo=0, and no done pulse ever appears for the aborted operation.
  - A new start then completes normally: a=12, b=12 unsigned -> lo=144.
- WIDTH=8 instance: a=0x80, b=0x7F, signed -> done after 9 cycles, hi=0xC0, lo=0x80. Follow with a randomized comparison of 1000 operations against a reference product in both modes.

Source files
------------

// File: rtl/booth_mult_param.sv
// rtl/booth_mult_param.sv - parametrised sequential radix-2 Booth multiplier (signed/unsigned)
//
// Purpose: computes the full 2*WIDTH-bit product of a and b, one Booth step
// per clock over WIDTH+1 steps. The result is held on hi/lo until the next
// operation completes.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   operation request, only sampled while idle
//   is_signed  in   1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a          in   multiplicand (sampled with start)
//   b          in   multiplier   (sampled with start)
//   hi         out  upper WIDTH bits of the product
//   lo         out  lower WIDTH bits of the product
//   busy       out  high while an operation is in progress
//   done       out  one-cycle pulse when hi/lo take a new result

module booth_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int CW = $clog2(WIDTH + 2);

    state_t           state_q, state_d;
    logic [WIDTH+1:0] m_q, m_d;         // extended multiplicand
    logic [WIDTH+1:0] acc_q, acc_d;     // accumulator A
    logic [WIDTH:0]   mq_q, mq_d;       // extended multiplier Q
    logic             qm1_q, qm1_d;     // Booth bit q_-1
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH+1:0] sum;
    logic             last_step;

    assign last_step = (cnt_q == CW'(WIDTH));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Booth add/subtract selection on {Q[0], q_-1}
    always_comb begin
        sum = acc_q;
        case ({mq_q[0], qm1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    // One extra bit on Q makes unsigned operands look like positive
                    // signed values; the second extra bit on M/A absorbs negating
                    // the most-negative multiplicand.
                    m_d   = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
                    mq_d  = is_signed ? {b[WIDTH-1], b} : {1'b0, b};
                    acc_d = '0;
                    qm1_d = 1'b0;
                    cnt_d = '0;
                end
            end
            RUN: begin
                // Arithmetic right shift of {A, Q, q_-1}
                acc_d = {sum[WIDTH+1], sum[WIDTH+1:1]};
                mq_d  = {sum[0], mq_q[WIDTH:1]};
                qm1_d = mq_q[0];
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = IDLE;
                    // product = {A, Q}[2*WIDTH-1:0]; higher bits are sign copies
                    hi_d    = {acc_d[WIDTH-2:0], mq_d[WIDTH]};
                    lo_d    = mq_d[WIDTH-1:0];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_booth_mult_param.sv
// tb/tb_booth_mult_param.sv - self-checking bench for booth_mult_param (WIDTH=32 and WIDTH=8)

module tb_booth_mult_param;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        start32, s32, busy32, done32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, s8, busy8, done8;
    logic [7:0]  a8, b8, hi8, lo8;

    booth_mult_param #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .is_signed(s32),
        .a(a32), .b(b32), .hi(hi32), .lo(lo32), .busy(busy32), .done(done32)
    );

    booth_mult_param #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .is_signed(s8),
        .a(a8), .b(b8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec32_t;

    vec32_t      vt[6];
    logic [63:0] q32[$];
    logic [15:0] q8[$];
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [15:0] pa, pb;
        pa = s ? {{8{a[7]}}, a} : {8'h00, a};
        pb = s ? {{8{b[7]}}, b} : {8'h00, b};
        return 16'(pa * pb);
    endfunction

    task automatic pop_check32(input string name);
        if (q32.size() == 0) begin
            total++;
            $display("FAIL %s: got done pulse required none (scoreboard empty)", name);
        end else begin
            check(name, {hi32, lo32}, q32.pop_front());
        end
    endtask

    task automatic pop_check8(input string name);
        if (q8.size() == 0) begin
            total++;
            $display("FAIL %s: got done pulse required none (scoreboard empty)", name);
        end else begin
            check(name, 64'({hi8, lo8}), 64'(q8.pop_front()));
        end
    endtask

    // Ends at the negedge just after the acceptance edge; operands are then
    // scrambled to show that changes during RUN are ignored.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic push, input logic [63:0] exp);
        @(negedge clock);
        start32 = 1'b1; a32 = a; b32 = b; s32 = s;
        if (push) q32.push_back(exp);
        @(negedge clock);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; s32 = ~s;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clock);
        start8 = 1'b1; a8 = a; b8 = b; s8 = s;
        q8.push_back(ref8(a, b, s));
        @(negedge clock);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s;
    endtask

    task automatic wait_done32(input string name, input int max, output int cyc);
        logic found;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < max) begin
            @(negedge clock);
            cyc++;
            if (done32) found = 1'b1;
        end
        if (!found) begin
            total++;
            $display("FAIL %s_timeout: got no done in %0d cycles required done", name, max);
        end else begin
            pop_check32(name);
        end
    endtask

    task automatic wait_done8(input string name, input int max, output int cyc);
        logic found;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < max) begin
            @(negedge clock);
            cyc++;
            if (done8) found = 1'b1;
        end
        if (!found) begin
            total++;
            $display("FAIL %s_timeout: got no done in %0d cycles required done", name, max);
        end else begin
            pop_check8(name);
        end
    endtask

    initial begin
        int cyc, bc, dn, d1, d2, nd;
        logic [31:0] hold_hi, hold_lo;

        reset = 1'b1;
        start32 = 1'b0; s32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; s8  = 1'b0; a8  = '0; b8  = '0;

        vt[0] = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
        vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
        vt[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vt[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
        vt[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};

        repeat (3) @(negedge clock);
        check("rst32_hilo", {hi32, lo32}, 64'd0);
        check("rst32_ctl", 64'({busy32, done32}), 64'd0);
        check("rst8_hilo", 64'({hi8, lo8}), 64'd0);
        check("rst8_ctl", 64'({busy8, done8}), 64'd0);
        reset = 1'b0;

        // Table-driven WIDTH=32 vectors
        for (int i = 0; i < 6; i++) begin
            issue32(vt[i].a, vt[i].b, vt[i].s, 1'b1, vt[i].exp);
            check($sformatf("vec%0d_busy", i), 64'(busy32), 64'd1);
            wait_done32($sformatf("vec%0d", i), 60, cyc);
            check($sformatf("vec%0d_lat", i), 64'(cyc), 64'd33);
            hold_hi = hi32; hold_lo = lo32;
            @(negedge clock);
            check($sformatf("vec%0d_pulse", i), 64'({busy32, done32}), 64'd0);
            check($sformatf("vec%0d_hold", i), {hi32, lo32}, {hold_hi, hold_lo});
        end

        // Ignored start while busy, then back-to-back issue in the done cycle
        issue32(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 64'h0000_0001_0000_0000);
        bc = busy32 ? 1 : 0;
        dn = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            start32 = 1'b0;
            if (c == 10) begin
                start32 = 1'b1; a32 = 32'h1234; b32 = 32'h5678; s32 = 1'b0;
            end
            if (busy32 && dn == 0) bc++;
            if (done32) begin
                dn++;
                if (dn == 1) begin
                    d1 = c;
                    pop_check32("hs_first");
                    start32 = 1'b1; a32 = 32'hFFFF_FFFB; b32 = 32'd100; s32 = 1'b1;
                    q32.push_back(64'hFFFF_FFFF_FFFF_FE0C);
                end else begin
                    d2 = c;
                    pop_check32("hs_second");
                end
            end
        end
        check("hs_done_count", 64'(dn), 64'd2);
        check("hs_busy_cycles", 64'(bc), 64'd33);
        check("hs_first_lat", 64'(d1), 64'd33);
        check("hs_b2b_gap", 64'(d2 - d1), 64'd34);

        // Reset in the middle of RUN
        issue32(32'h0000_0123, 32'h0000_0456, 1'b0, 1'b0, 64'd0);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_hilo", {hi32, lo32}, 64'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clock);
            if (done32) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        issue32(32'd12, 32'd12, 1'b0, 1'b1, 64'd144);
        wait_done32("after_abort", 60, cyc);
        check("after_abort_lat", 64'(cyc), 64'd33);

        // WIDTH=8 instance
        issue8(8'h80, 8'h7F, 1'b1);
        wait_done8("w8_corner", 30, cyc);
        check("w8_corner_lat", 64'(cyc), 64'd9);
        check("w8_corner_const", 64'({hi8, lo8}), 64'h0000_0000_0000_C080);

        for (int i = 0; i < 1000; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            wait_done8($sformatf("w8_rand%0d", i), 30, cyc);
        end

        check("sb32_empty", 64'(q32.size()), 64'd0);
        check("sb8_empty", 64'(q8.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
